decoder_nx_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder. It is the successor of the team's fixed 2-to-4 combinational decoder.
- Adds a valid/ready handshake on both input and output, with one register stage.
- Adds a self-timed SCAN mode that walks the one-hot output across all lines. Used for LED/digit multiplexing and for driving chip-selects from a sequenced controller.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_nx_scan_ctr.sv | 37 +++
 rtl/decoder_nx_seq.sv | 107 ++++++++++
 tb/tb_decoder_nx_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the N-to-2^N registered decoder.
package decoder_pkg;

  typedef enum logic {
    ST_DIRECT,
    ST_SCAN
  } state_t;

  localparam int SEL_W_MAX = 8;
  localparam int OUT_W_MAX = 2 ** SEL_W_MAX;

  function automatic logic [OUT_W_MAX-1:0] onehot(
    input int unsigned idx
  );
    return OUT_W_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/decoder_nx_scan_ctr.sv
// Scan sweep counters: div paces each line, idx walks the lines.
module decoder_nx_scan_ctr
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  output logic [SEL_W-1:0] idx
);

  localparam int DIV_W =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;

  // idx wraps for free: OUT_W is exactly 2**SEL_W
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div <= '0;
      idx <= '0;
    end else if (run) begin
      if (div == DIV_MAX) begin
        div <= '0;
        idx <= idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered one-hot decoder with valid/ready and a self-timed scan.
// Define DECODER_NX_ACTLOW_EN for an active-low (one-cold) out bus.
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             scan_en,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_q, state_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ctr_clear, ctr_run;
  logic [SEL_W-1:0] idx;
  logic [OUT_W-1:0] out_oh;
  logic             slot_free;

  decoder_nx_scan_ctr #(
    .SEL_W   (SEL_W),
    .SCAN_DIV(SCAN_DIV)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clear(ctr_clear),
    .run  (ctr_run),
    .idx  (idx)
  );

  assign slot_free = !vld_q || out_ready;
  assign in_ready  = (state_q == ST_DIRECT)
                  && !scan_en && slot_free;

  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    sel_d     = sel_q;
    ctr_clear = 1'b0;
    ctr_run   = 1'b0;
    unique case (state_q)
      ST_DIRECT: begin
        if (scan_en && slot_free) begin
          state_d   = ST_SCAN;
          ctr_clear = 1'b1;
          vld_d     = 1'b1;
          sel_d     = '0;
        end else if (in_valid && in_ready) begin
          vld_d = 1'b1;
          sel_d = sel_in;
        end else if (vld_q && out_ready) begin
          vld_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (!scan_en) begin
          state_d   = ST_DIRECT;
          ctr_clear = 1'b1;
          vld_d     = 1'b0;
          sel_d     = '0;
        end else begin
          ctr_run = 1'b1;
        end
      end
      default: state_d = ST_DIRECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DIRECT;
      vld_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      sel_q   <= sel_d;
    end
  end

  // in scan the index comes straight from the counter register
  always_comb begin
    out_sel = sel_q;
    if (state_q == ST_SCAN) out_sel = idx;
    out_oh = '0;
    if (vld_q) out_oh = OUT_W'(onehot(32'(out_sel)));
  end

  assign out_valid = vld_q;

`ifdef DECODER_NX_ACTLOW_EN
  assign out = ~out_oh;
`else
  assign out = out_oh;
`endif

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Directed bench for decoder_nx_seq: 4-line (div 2) and 8-line (div 1).
module tb_decoder_nx_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel_in;
  logic       in_valid, in_ready, scan_en, out_ready;
  logic [3:0] out;
  logic [1:0] out_sel;
  logic       out_valid;

  logic [2:0] sel8;
  logic       iv8, ir8, se8, ordy8;
  logic [7:0] out8;
  logic [2:0] osel8;
  logic       ov8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_nx_seq #(.SEL_W(2), .SCAN_DIV(2)) u4 (
    .clk(clk), .rst(rst), .sel_in(sel_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .scan_en(scan_en), .out(out), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  decoder_nx_seq #(.SEL_W(3), .SCAN_DIV(1)) u8 (
    .clk(clk), .rst(rst), .sel_in(sel8),
    .in_valid(iv8), .in_ready(ir8),
    .scan_en(se8), .out(out8), .out_sel(osel8),
    .out_valid(ov8), .out_ready(ordy8)
  );

  function automatic logic [7:0] pol(input logic [7:0] oh, input int w);
    logic [7:0] m;
    m = (w == 8) ? 8'hff : 8'h0f;
`ifdef DECODER_NX_ACTLOW_EN
    return ~oh & m;
`else
    return oh & m;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] oh,
                      input logic v, input logic [1:0] s);
    chk({tag, ".out"}, 32'(out), 32'(pol({4'h0, oh}, 4)));
    chk({tag, ".vld"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"}, 32'(out_sel), 32'(s));
  endtask

  initial begin
    logic [1:0] scan_seq [8];
    scan_seq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    rst = 1'b1; sel_in = '0; in_valid = 0; scan_en = 0; out_ready = 1;
    sel8 = '0; iv8 = 0; se8 = 0; ordy8 = 1;
    tick; tick;
    chk4("reset", 4'h0, 0, 2'd0);
    chk("reset8.out", 32'(out8), 32'(pol(8'h00, 8)));
    rst = 1'b0;

    // 1: full-throughput sweep
    in_valid = 1; sel_in = 2'd0;
    #1 chk("t1.rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk4($sformatf("t1.s%0d", i), 4'(1 << i), 1, 2'(i));
      sel_in = 2'(i + 1);
    end

    // 2: stall then resume
    sel_in = 2'd2; tick;
    chk4("t2.acc", 4'b0100, 1, 2'd2);
    out_ready = 0; sel_in = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2.rdy", 32'(in_ready), 32'd0);
      tick;
      chk4("t2.hold", 4'b0100, 1, 2'd2);
    end
    out_ready = 1;
    #1 chk("t2.rdy1", 32'(in_ready), 32'd1);
    tick;
    chk4("t2.next", 4'b0010, 1, 2'd1);
    in_valid = 0; tick;
    chk4("t2.drain", 4'b0000, 0, 2'd1);

    // 3: scan from idle
    scan_en = 1;
    #1 chk("t3.rdy", 32'(in_ready), 32'd0);
    tick;
    chk4("t3.entry", 4'b0001, 1, 2'd0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk4($sformatf("t3.k%0d", i), 4'(1 << scan_seq[i]), 1, scan_seq[i]);
      chk("t3.rdy", 32'(in_ready), 32'd0);
    end

    // 5: drop scan mid-sweep, then restart
    repeat (4) tick;
    chk4("t5.mid", 4'b0100, 1, 2'd2);
    scan_en = 0; tick;
    chk4("t5.exit", 4'b0000, 0, 2'd0);
    chk("t5.rdy", 32'(in_ready), 32'd1);
    scan_en = 1; tick;
    chk4("t5.restart", 4'b0001, 1, 2'd0);
    scan_en = 0; tick;

    // 4: scan requested behind a stalled output
    in_valid = 1; sel_in = 2'd2; tick;
    chk4("t4.acc", 4'b0100, 1, 2'd2);
    out_ready = 0; scan_en = 1; sel_in = 2'd3;
    #1 chk("t4.rdy", 32'(in_ready), 32'd0);
    repeat (2) begin
      tick;
      chk4("t4.hold", 4'b0100, 1, 2'd2);
    end
    out_ready = 1;
    #1 chk("t4.rdy1", 32'(in_ready), 32'd0);
    tick;
    chk4("t4.scan", 4'b0001, 1, 2'd0);
    in_valid = 0;

    // 6: reset during scan and during a stall
    tick;
    rst = 1; tick;
    chk4("t6.rscan", 4'b0000, 0, 2'd0);
    rst = 0; scan_en = 0;
    in_valid = 1; sel_in = 2'd3; tick;
    chk4("t6.acc", 4'b1000, 1, 2'd3);
    out_ready = 0; in_valid = 0; tick;
    chk4("t6.hold", 4'b1000, 1, 2'd3);
    rst = 1; tick;
    chk4("t6.rstall", 4'b0000, 0, 2'd0);
    rst = 0; out_ready = 1;

    // 8-line, div 1: direct accept then full wrap
    iv8 = 1; sel8 = 3'd5; tick;
    chk("w8.acc", 32'(out8), 32'(pol(8'h20, 8)));
    iv8 = 0; se8 = 1; tick;
    chk("w8.entry", 32'(out8), 32'(pol(8'h01, 8)));
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk($sformatf("w8.k%0d", i), 32'(out8),
          32'(pol(8'(1 << (i % 8)), 8)));
      chk("w8.sel", 32'(osel8), 32'(i % 8));
    end
    rst = 1; tick;
    chk("w8.rst", 32'(out8), 32'(pol(8'h00, 8)));
    chk("w8.rvld", 32'(ov8), 32'd0);
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
